axis_pkt_len_tagger: RTL

- Store-and-forward stage directly upstream of merge_pkt, between the pcap_parse source and merge_pkt s_axis.
- Buffers each 512-bit AXI-Stream packet fully, counts its bytes from tkeep, and replays it with tuser[15:0] = total packet byte length on every beat.
- merge_pkt can then rely on a valid length from the first beat.
- Over-long packets are truncated and flagged instead of deadlocking.

---
 rtl/axis_pkt_len_tagger.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_len_tagger.sv
// axis_pkt_len_tagger
//   Store-and-forward AXI-Stream stage. Each packet is buffered whole while
//   its bytes are counted from tkeep. It is then replayed with
//   tuser[LEN_W-1:0] = total byte length on every beat, so the downstream
//   merge logic has a valid length from the first beat onward. A packet
//   longer than DEPTH beats is cut at DEPTH beats, flagged in tuser[USER_W-1],
//   and the rest of it is discarded.
//
//   Optional feature: define AXIS_LEN_TAG_SEQ_EN to store a 16-bit packet
//   sequence number with each length entry and present it on tuser[31:16].
//   When it is undefined, tuser[31:16] is 0.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     s_axis_*          input stream (tuser ignored)
//     m_axis_*          output stream; tuser = {trunc, 0.., [seq], len}
//     pkt_count         packets emitted (wraps)
//     trunc_count       truncated packets emitted (saturates)
module axis_pkt_len_tagger #(
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = 64,
  parameter int USER_W    = 48,
  parameter int DEPTH     = 64,
  parameter int LEN_DEPTH = 16,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [15:0]       pkt_count,
  output logic [15:0]       trunc_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LAW    = $clog2(LEN_DEPTH);
  localparam int WORD_W = DATA_W + KEEP_W + 1;
`ifdef AXIS_LEN_TAG_SEQ_EN
  localparam int ENT_W  = 1 + 16 + LEN_W;
`else
  localparam int ENT_W  = 1 + LEN_W;
`endif

  typedef enum logic {ACCUM, DROP} state_t;
  state_t state, state_next;

  // data FIFO: {tdata, tkeep, tlast}
  logic [WORD_W-1:0] data_mem [DEPTH];
  logic [AW:0]       data_wr, data_rd;
  logic              data_full;

  // length FIFO: {trunc, [seq], len}
  // len_ld runs ahead of len_rd: it selects the entry for the beats being
  // loaded into the output register, while len_rd only advances once the
  // tlast beat has actually left.
  logic [ENT_W-1:0]  len_mem [LEN_DEPTH];
  logic [LAW:0]      len_wr, len_rd, len_ld;
  logic              len_full;

  logic [LEN_W-1:0]  byte_acc, len_total;
  logic [AW-1:0]     beat_cnt;
  logic              wr_en, wr_last, push, push_trunc;
  logic [ENT_W-1:0]  push_entry, head;
`ifdef AXIS_LEN_TAG_SEQ_EN
  logic [15:0]       seq;
`endif

  // Complete packets visible to the read side and not yet loaded into the
  // output register. A commit becomes visible one cycle after it happens,
  // so the read-side start decision is fed from a register rather than
  // from the input tlast/popcount path.
  logic              commit_q;
  logic [LAW:0]      pkts_ready;

  logic [WORD_W-1:0] rd_word;
  logic              rd_last, out_adv, load, out_pop;
  logic [USER_W-1:0] user_next;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  function automatic logic [LEN_W-1:0] popcount(input logic [KEEP_W-1:0] k);
    logic [LEN_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) c = c + LEN_W'(k[i]);
    return c;
  endfunction

  assign data_full = (data_wr[AW] != data_rd[AW]) &&
                     (data_wr[AW-1:0] == data_rd[AW-1:0]);
  assign len_full  = (len_wr[LAW] != len_rd[LAW]) &&
                     (len_wr[LAW-1:0] == len_rd[LAW-1:0]);
  assign len_total = byte_acc + popcount(s_axis_tkeep);

`ifdef AXIS_LEN_TAG_SEQ_EN
  assign push_entry = {push_trunc, seq, len_total};
`else
  assign push_entry = {push_trunc, len_total};
`endif

  // input FSM: next state, ready and write/commit strobes
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    wr_en         = 1'b0;
    wr_last       = s_axis_tlast;
    push          = 1'b0;
    push_trunc    = 1'b0;
    if (!rst) begin
      case (state)
        ACCUM: begin
          s_axis_tready = !data_full && !len_full;
          if (s_axis_tvalid && !data_full && !len_full) begin
            wr_en = 1'b1;
            if (s_axis_tlast) begin
              push = 1'b1;
            end else if (beat_cnt == AW'(DEPTH - 1)) begin
              wr_last    = 1'b1;
              push       = 1'b1;
              push_trunc = 1'b1;
              state_next = DROP;
            end
          end
        end
        DROP: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) state_next = ACCUM;
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  // read side
  assign rd_word = data_mem[data_rd[AW-1:0]];
  assign rd_last = rd_word[0];
  assign out_adv = !m_axis_tvalid || m_axis_tready;
  assign load    = out_adv && (pkts_ready != '0);
  assign out_pop = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    head      = len_mem[len_ld[LAW-1:0]];
    user_next = '0;
    user_next[LEN_W-1:0] = head[LEN_W-1:0];
    user_next[USER_W-1]  = head[ENT_W-1];
`ifdef AXIS_LEN_TAG_SEQ_EN
    user_next[31:16]     = head[LEN_W+15:LEN_W];
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_mem[data_wr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, wr_last};
    if (push)  len_mem[len_wr[LAW-1:0]]  <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      data_wr       <= '0;
      data_rd       <= '0;
      len_wr        <= '0;
      len_rd        <= '0;
      len_ld        <= '0;
      byte_acc      <= '0;
      beat_cnt      <= '0;
      commit_q      <= 1'b0;
      pkts_ready    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_count     <= '0;
      trunc_count   <= '0;
`ifdef AXIS_LEN_TAG_SEQ_EN
      seq           <= '0;
`endif
    end else begin
      state <= state_next;

      if (wr_en) begin
        data_wr <= data_wr + (AW+1)'(1);
        if (push) begin
          byte_acc <= '0;
          beat_cnt <= '0;
        end else begin
          byte_acc <= len_total;
          beat_cnt <= beat_cnt + AW'(1);
        end
      end

      if (push) begin
        len_wr <= len_wr + (LAW+1)'(1);
`ifdef AXIS_LEN_TAG_SEQ_EN
        seq    <= seq + 16'd1;
`endif
      end

      commit_q   <= push;
      pkts_ready <= pkts_ready + (LAW+1)'(commit_q) - (LAW+1)'(load && rd_last);

      if (load) begin
        data_rd       <= data_rd + (AW+1)'(1);
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= rd_word[WORD_W-1:KEEP_W+1];
        m_axis_tkeep  <= rd_word[KEEP_W:1];
        m_axis_tlast  <= rd_last;
        m_axis_tuser  <= user_next;
        if (rd_last) len_ld <= len_ld + (LAW+1)'(1);
      end else if (out_adv) begin
        m_axis_tvalid <= 1'b0;
      end

      if (out_pop) begin
        len_rd    <= len_rd + (LAW+1)'(1);
        pkt_count <= pkt_count + 16'd1;
        if (m_axis_tuser[USER_W-1] && trunc_count != '1)
          trunc_count <= trunc_count + 16'd1;
      end
    end
  end

endmodule
